// File: rtl/sw_cond_pkg.sv
`default_nettype none
//==============================================================================
// sw_cond_pkg: shared types and helpers for the switch conditioner.
// Revision: 1.0
//==============================================================================
package sw_cond_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } deb_state_t;

    localparam int c_MAX_CH = 32;

    function automatic int unsigned popcount(input logic [c_MAX_CH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_MAX_CH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Index of the highest set bit; callers only use it when exactly one bit is set.
    function automatic int unsigned onehot_to_idx(input logic [c_MAX_CH-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < c_MAX_CH; i++) begin
            if (v[i]) begin
                idx = 32'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_ch.sv
`default_nettype none
//==============================================================================
// sw_debounce_ch: one channel - synchroniser, debounce FSM, clean level, rise pulse.
// Revision: 1.0
//==============================================================================
module sw_debounce_ch
    import sw_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    deb_state_t             r_state, w_state_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic                   w_clean_d, w_rise_d;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_state  <= ST_LOW;
            r_cnt    <= '0;
            sw_clean <= 1'b0;
            sw_rise  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sw_raw};
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            sw_clean <= w_clean_d;
            sw_rise  <= w_rise_d;
        end
    end

    // The counter holds the number of consecutive cycles the new level has been seen.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_clean_d = sw_clean;
        w_rise_d  = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_sync) begin
                    w_state_d = ST_CHK_HIGH;
                    w_cnt_d   = c_CNT_ONE;
                end else begin
                    w_cnt_d = '0;
                end
            end
            ST_CHK_HIGH: begin
                if (!w_sync) begin
                    w_state_d = ST_LOW;
                    w_cnt_d   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_d = ST_HIGH;
                    w_cnt_d   = '0;
                    w_clean_d = 1'b1;
                    w_rise_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + c_CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!w_sync) begin
                    w_state_d = ST_CHK_LOW;
                    w_cnt_d   = c_CNT_ONE;
                end else begin
                    w_cnt_d = '0;
                end
            end
            ST_CHK_LOW: begin
                if (w_sync) begin
                    w_state_d = ST_HIGH;
                    w_cnt_d   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_d = ST_LOW;
                    w_cnt_d   = '0;
                    w_clean_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_d = ST_LOW;
                w_cnt_d   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/switch_conditioner.sv
`default_nettype none
//==============================================================================
// switch_conditioner: debounced switch levels, rise pulses and one-hot command strobe.
// Revision: 1.0
//==============================================================================
module switch_conditioner
    import sw_cond_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SW-1:0]         sw_raw,
    output logic [N_SW-1:0]         sw_clean,
    output logic [N_SW-1:0]         sw_rise,
    output logic                    cmd_valid,
    output logic [$clog2(N_SW)-1:0] cmd_sel,
    output logic                    multi_err
);

    localparam int SEL_W = $clog2(N_SW);

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
            sw_debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .sw_raw  (sw_raw[gi]),
                .sw_clean(sw_clean[gi]),
                .sw_rise (sw_rise[gi])
            );
        end
    endgenerate

    int unsigned      w_pop;
    logic [SEL_W-1:0] w_idx;

    always_comb begin
        w_pop = popcount(c_MAX_CH'(sw_clean));
        w_idx = SEL_W'(onehot_to_idx(c_MAX_CH'(sw_clean)));
    end

    // sw_clean already reflects a rise in the cycle sw_rise pulses, so both are judged together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_sel   <= '0;
            multi_err <= 1'b0;
        end else begin
            cmd_valid <= (|sw_rise) && (w_pop == 32'd1);
            multi_err <= (w_pop > 32'd1);
            if ((|sw_rise) && (w_pop == 32'd1)) begin
                cmd_sel <= w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
//==============================================================================
// tb_switch_conditioner: directed and random stimulus against a windowed reference model.
// Revision: 1.0
//==============================================================================
module tb_switch_conditioner;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int H  = SS + DC;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_clean, sw_rise;
    logic         cmd_valid, multi_err;
    logic [1:0]   cmd_sel;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: raw history (index = edges ago) and expected outputs.
    logic [N-1:0] hist [H];
    logic [N-1:0] m_clean, m_rise;
    logic         m_cv, m_me;
    logic [1:0]   m_sel;

    switch_conditioner #(
        .N_SW(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw),
        .sw_clean(sw_clean), .sw_rise(sw_rise),
        .cmd_valid(cmd_valid), .cmd_sel(cmd_sel), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // A level is accepted once the synchronised input has shown it for DC consecutive edges.
    task automatic model_edge();
        logic [N-1:0] pc, pr;
        int           ones;
        bit           all1, all0;
        if (reset) begin
            for (int j = 0; j < H; j++) hist[j] = '0;
            m_clean = '0; m_rise = '0; m_cv = 1'b0; m_me = 1'b0; m_sel = '0;
        end else begin
            pc = m_clean;
            pr = m_rise;
            for (int j = H - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sw_raw;
            m_rise = '0;
            for (int c = 0; c < N; c++) begin
                all1 = 1'b1; all0 = 1'b1;
                for (int j = SS; j < H; j++) begin
                    if (hist[j][c]) all0 = 1'b0;
                    else all1 = 1'b0;
                end
                if (!m_clean[c] && all1) begin
                    m_clean[c] = 1'b1;
                    m_rise[c]  = 1'b1;
                end else if (m_clean[c] && all0) begin
                    m_clean[c] = 1'b0;
                end
            end
            ones = $countones(pc);
            m_cv = (|pr) && (ones == 1);
            m_me = (ones > 1);
            if (m_cv) begin
                for (int c = 0; c < N; c++) if (pc[c]) m_sel = 2'(c);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sw_clean",  32'(sw_clean),  32'(m_clean));
        check("sw_rise",   32'(sw_rise),   32'(m_rise));
        check("cmd_valid", 32'(cmd_valid), 32'(m_cv));
        check("multi_err", 32'(multi_err), 32'(m_me));
        if (m_cv) check("cmd_sel", 32'(cmd_sel), 32'(m_sel));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int mode;
        reset  = 1'b1;
        sw_raw = 4'b1111;
        for (int j = 0; j < H; j++) hist[j] = '0;
        m_clean = '0; m_rise = '0; m_cv = 1'b0; m_me = 1'b0; m_sel = '0;

        // Reset with all switches held high.
        #2;
        check("rst_clean", 32'(sw_clean), 32'h0);
        check("rst_cmd",   32'({cmd_valid, multi_err, cmd_sel}), 32'h0);
        steps(2);
        reset = 1'b0;
        steps(5);
        check("rst_pre6_clean", 32'(sw_clean), 32'h0);
        step();
        check("rst_e6_clean", 32'(sw_clean), 32'hF);
        step();
        check("rst_e7_merr", 32'(multi_err), 32'h1);
        check("rst_e7_cv",   32'(cmd_valid), 32'h0);
        sw_raw = 4'b0000;
        steps(10);

        // Single press on channel 0.
        sw_raw = 4'b0001;
        steps(5);
        check("p0_pre6_rise", 32'(sw_rise), 32'h0);
        step();
        check("p0_e6_clean", 32'(sw_clean), 32'h1);
        check("p0_e6_rise",  32'(sw_rise),  32'h1);
        step();
        check("p0_e7_cv",   32'(cmd_valid), 32'h1);
        check("p0_e7_sel",  32'(cmd_sel),   32'h0);
        check("p0_e7_merr", 32'(multi_err), 32'h0);
        check("p0_e7_rise", 32'(sw_rise),   32'h0);

        // Short glitches on channel 1 are rejected.
        for (int k = 0; k < 5; k++) begin
            sw_raw = 4'b0011; steps(3);
            sw_raw = 4'b0001; steps(3);
        end
        check("glitch_clean", 32'(sw_clean), 32'h1);

        // Second channel pressed while channel 0 held.
        sw_raw = 4'b0101;
        steps(5);
        step();
        check("p2_e6_rise", 32'(sw_rise), 32'h4);
        step();
        check("p2_e7_cv",   32'(cmd_valid), 32'h0);
        check("p2_e7_merr", 32'(multi_err), 32'h1);
        sw_raw = 4'b0100;
        steps(6);
        check("p2_drop_clean", 32'(sw_clean),  32'h4);
        check("p2_drop_merr",  32'(multi_err), 32'h1);
        step();
        check("p2_drop_merr1", 32'(multi_err), 32'h0);
        check("p2_drop_cv",    32'(cmd_valid), 32'h0);

        // Release: falling edge produces no pulse.
        sw_raw = 4'b0000;
        steps(5);
        step();
        check("rel_e6_clean", 32'(sw_clean), 32'h0);
        check("rel_e6_rise",  32'(sw_rise),  32'h0);
        step();
        check("rel_e7_cv", 32'(cmd_valid), 32'h0);
        steps(4);

        // Reset in the middle of debouncing channel 3.
        sw_raw = 4'b1000;
        steps(3);
        reset = 1'b1;
        #1;
        check("mid_rst_clean", 32'(sw_clean), 32'h0);
        step();
        reset = 1'b0;
        steps(5);
        check("mid_pre6_clean", 32'(sw_clean), 32'h0);
        step();
        check("mid_e6_clean", 32'(sw_clean), 32'h8);
        step();
        check("mid_e7_cv",  32'(cmd_valid), 32'h1);
        check("mid_e7_sel", 32'(cmd_sel),   32'h3);

        // Random bouncing, calm stretches and occasional resets.
        mode = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 60 == 0) mode = int'($urandom_range(0, 1));
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, (mode != 0) ? 2 : 24) == 0) sw_raw[c] = ~sw_raw[c];
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
